// File: rtl/alu_iterative.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_iterative: per-thread ALU, single-cycle ADD/SUB/CMP, iterative MUL/DIV.
// Define ALU_DIV_EN to build the restoring divider. Revision: 1.0
// ----------------------------------------------------------------------------
module alu_iterative #(
  parameter int WIDTH      = 8,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic [2:0]       nzp,
  output logic             div_zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  // a: multiplicand / dividend-then-quotient; b: multiplier / divisor;
  // acc: product / partial remainder
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [2:0]       nzp_q, nzp_d;
  logic             div_zero_q, div_zero_d;
  logic             cmp_lt;
  logic             cmp_eq;
  logic [2:0]       cmp_nzp;
`ifdef ALU_DIV_EN
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    done_d     = 1'b0;
    alu_out_d  = alu_out_q;
    nzp_d      = nzp_q;
    div_zero_d = div_zero_q;
`ifdef ALU_DIV_EN
    is_div_d   = is_div_q;
    rem_shift  = '0;
    rem_diff   = '0;
`endif

    if (SIGNED_CMP) cmp_lt = $signed(rs) < $signed(rt);
    else            cmp_lt = rs < rt;
    cmp_eq  = (rs == rt);
    cmp_nzp = {cmp_lt, cmp_eq, ~cmp_lt & ~cmp_eq};

    case (state_q)
      IDLE: begin
        if (start && enable) begin
          case (op)
            OP_ADD: begin
              done_d     = 1'b1;
              alu_out_d  = rs + rt;
              div_zero_d = 1'b0;
            end
            OP_SUB: begin
              done_d     = 1'b1;
              alu_out_d  = rs - rt;
              div_zero_d = 1'b0;
            end
            OP_CMP: begin
              done_d     = 1'b1;
              alu_out_d  = {{(WIDTH-3){1'b0}}, cmp_nzp};
              nzp_d      = cmp_nzp;
              div_zero_d = 1'b0;
            end
            OP_MUL: begin
              state_d = RUN;
              count_d = CW'(WIDTH);
              a_d     = rs;
              b_d     = rt;
              acc_d   = '0;
`ifdef ALU_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
              state_d  = RUN;
              count_d  = CW'(WIDTH);
              a_d      = rs;
              b_d      = rt;
              acc_d    = '0;
              is_div_d = 1'b1;
            end
`endif
            default: begin
              done_d     = 1'b1;
              alu_out_d  = '0;
              div_zero_d = 1'b0;
            end
          endcase
        end
      end

      RUN: begin
        if (enable) begin
          count_d = count_q - CW'(1);
`ifdef ALU_DIV_EN
          if (is_div_q) begin
            // Restoring step: remainder stays below the divisor, so WIDTH bits hold it
            rem_shift = {acc_q, a_q[WIDTH-1]};
            rem_diff  = rem_shift - {1'b0, b_q};
            if (!rem_diff[WIDTH]) begin
              acc_d = rem_diff[WIDTH-1:0];
              a_d   = {a_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = rem_shift[WIDTH-1:0];
              a_d   = {a_q[WIDTH-2:0], 1'b0};
            end
          end else
`endif
          begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = a_q << 1;
            b_d = b_q >> 1;
          end

          if (count_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef ALU_DIV_EN
            alu_out_d  = is_div_q ? a_d : acc_d;
            div_zero_d = is_div_q && (b_q == '0);
`else
            alu_out_d  = acc_d;
            div_zero_d = 1'b0;
`endif
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
      alu_out_q  <= '0;
      nzp_q      <= 3'b000;
      div_zero_q <= 1'b0;
`ifdef ALU_DIV_EN
      is_div_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
      alu_out_q  <= alu_out_d;
      nzp_q      <= nzp_d;
      div_zero_q <= div_zero_d;
`ifdef ALU_DIV_EN
      is_div_q   <= is_div_d;
`endif
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign alu_out  = alu_out_q;
  assign nzp      = nzp_q;
  assign div_zero = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_iterative.sv
`default_nettype none
// Directed self-checking bench for alu_iterative (WIDTH=8); a second instance
// with SIGNED_CMP=1 shares the stimulus to check signed compares.
module tb_alu_iterative;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'b000;
  logic [7:0] rs = 8'd0;
  logic [7:0] rt = 8'd0;

  logic       busy, done, div_zero;
  logic [7:0] alu_out;
  logic [2:0] nzp;
  logic       busy_s, done_s, div_zero_s;
  logic [7:0] alu_out_s;
  logic [2:0] nzp_s;

  int total = 0;
  int bad   = 0;
  int cyc;
  int dcount;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010,
                         DIV = 3'b011, CMP = 3'b100, NOP = 3'b101;

`ifdef ALU_DIV_EN
  localparam logic [2:0] LONG_OP  = DIV;
  localparam logic [7:0] LONG_EXP = 8'd14;   // 100 / 7
`else
  localparam logic [2:0] LONG_OP  = MUL;
  localparam logic [7:0] LONG_EXP = 8'd188;  // 700 mod 256
`endif

  alu_iterative #(.WIDTH(8), .SIGNED_CMP(1'b0)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .op(op),
    .rs(rs), .rt(rt), .busy(busy), .done(done), .alu_out(alu_out),
    .nzp(nzp), .div_zero(div_zero)
  );

  alu_iterative #(.WIDTH(8), .SIGNED_CMP(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .op(op),
    .rs(rs), .rt(rt), .busy(busy_s), .done(done_s), .alu_out(alu_out_s),
    .nzp(nzp_s), .div_zero(div_zero_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one accept edge; returns in cycle t+1
  task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    step();
    start = 1'b0;
  endtask

  // Advance until done, counting cycles after the accept edge (bounded)
  task automatic wait_done(input int from, output int c);
    c = from;
    while (done !== 1'b1 && c < 60) begin
      step();
      c++;
    end
  endtask

  initial begin
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_nzp", nzp, 0);
    chk("rst_div_zero", div_zero, 0);
    reset = 1'b0;
    step();

    // Single-cycle ops
    issue(ADD, 8'd200, 8'd100);
    chk("add_done", done, 1);
    chk("add_result", alu_out, 8'd44);
    chk("add_busy", busy, 0);
    step();
    chk("add_done_drops", done, 0);

    issue(SUB, 8'd5, 8'd9);
    chk("sub_result", alu_out, 8'd252);

    issue(CMP, 8'd5, 8'd9);
    chk("cmp_lt_result", alu_out, 8'h04);
    chk("cmp_lt_nzp", nzp, 3'b100);
    chk("cmp_lt_nzp_signed", nzp_s, 3'b100);

    issue(CMP, 8'hFB, 8'd9);
    chk("cmp_fb_nzp_unsigned", nzp, 3'b001);
    chk("cmp_fb_result", alu_out, 8'h01);
    chk("cmp_fb_nzp_signed", nzp_s, 3'b100);

    issue(CMP, 8'd7, 8'd7);
    chk("cmp_eq_nzp", nzp, 3'b010);

    issue(NOP, 8'd3, 8'd4);
    chk("nop_done", done, 1);
    chk("nop_result", alu_out, 0);
    chk("nop_nzp_held", nzp, 3'b010);

    // Iterative multiply
    issue(MUL, 8'd13, 8'd11);
    chk("mul_busy_t1", busy, 1);
    chk("mul_done_t1", done, 0);
    wait_done(1, cyc);
    chk("mul_done_cycle", cyc, 9);
    chk("mul_result", alu_out, 8'd143);
    chk("mul_busy_at_done", busy, 0);
    step();
    chk("mul_done_pulse", done, 0);

    // Multiply with enable low for 3 RUN cycles
    issue(MUL, 8'd13, 8'd11);
    enable = 1'b0;
    repeat (3) step();
    chk("frz_busy", busy, 1);
    chk("frz_done", done, 0);
    enable = 1'b1;
    wait_done(4, cyc);
    chk("frz_done_cycle", cyc, 12);
    chk("frz_result", alu_out, 8'd143);

    issue(MUL, 8'd255, 8'd255);
    wait_done(1, cyc);
    chk("mul_max_result", alu_out, 8'd1);

`ifdef ALU_DIV_EN
    issue(DIV, 8'd100, 8'd7);
    chk("div_busy_t1", busy, 1);
    wait_done(1, cyc);
    chk("div_done_cycle", cyc, 9);
    chk("div_result", alu_out, 8'd14);
    chk("div_zero_flag_clear", div_zero, 0);

    issue(DIV, 8'd100, 8'd0);
    wait_done(1, cyc);
    chk("div0_done_cycle", cyc, 9);
    chk("div0_result", alu_out, 8'hFF);
    chk("div0_flag", div_zero, 1);
    issue(ADD, 8'd1, 8'd1);
    chk("div0_flag_cleared", div_zero, 0);
`else
    issue(DIV, 8'd100, 8'd7);
    chk("div_off_done", done, 1);
    chk("div_off_result", alu_out, 0);
    chk("div_off_busy", busy, 0);
    chk("div_off_flag", div_zero, 0);
`endif

    // Start while busy is ignored; start on the done cycle is accepted
    issue(LONG_OP, 8'd100, 8'd7);
    step();
    step();
    issue(ADD, 8'd1, 8'd1);
    chk("ign_done", done, 0);
    chk("ign_busy", busy, 1);
    wait_done(4, cyc);
    chk("ign_done_cycle", cyc, 9);
    chk("ign_result", alu_out, LONG_EXP);
    issue(ADD, 8'd3, 8'd4);
    chk("b2b_done", done, 1);
    chk("b2b_result", alu_out, 8'd7);

    // Reset while running aborts without a done
    issue(LONG_OP, 8'd100, 8'd7);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_alu_out", alu_out, 0);
    chk("abort_done", done, 0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);

    // Start with enable low is ignored
    enable = 1'b0;
    issue(ADD, 8'd1, 8'd1);
    chk("en_off_done", done, 0);
    chk("en_off_busy", busy, 0);
    enable = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
